// File: rtl/ad7643_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ad7643_reader                                              |
// | Description : Conversion/readout controller for an AD7643-style 18-bit   |
// |               SAR ADC. Pulses ADCNVST, waits for a BUSY high->low        |
// |               cycle (with timeout), then clocks 18 bits out MSB first.   |
// |               All sequential logic runs on the falling edge of CLK.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   CLK      in   1   system clock (falling edge active)                   |
// |   RSTN     in   1   asynchronous active-low reset                        |
// |   START    in   1   single-conversion request, honoured only in IDLE     |
// |   CONT     in   1   continuous mode: restart after every sample          |
// |   ADCNVST  out  1   conversion start pulse to ADC                        |
// |   ADCS     out  1   ADC chip select, active-low                          |
// |   ADSCLK   out  1   ADC serial clock                                     |
// |   ADSDOUT  in   1   ADC serial data, MSB first                           |
// |   ADBUSY   in   1   ADC busy, asynchronous                               |
// |   DATA     out  18  last completed sample                                |
// |   DVALID   out  1   one-cycle strobe, DATA new this cycle                |
// |   READY    out  1   high only in IDLE                                    |
// |   ERR      out  1   sticky BUSY timeout flag                             |
// |   COUNT    out  16  completed-sample counter (wraps)                     |
// +--------------------------------------------------------------------------+
module ad7643_reader #(
  parameter int CNV_PULSE    = 4,
  parameter int SCLK_DIV     = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic        CONT,
  output logic        ADCNVST,
  output logic        ADCS,
  output logic        ADSCLK,
  input  logic        ADSDOUT,
  input  logic        ADBUSY,
  output logic [17:0] DATA,
  output logic        DVALID,
  output logic        READY,
  output logic        ERR,
  output logic [15:0] COUNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNV   = 3'd1,
    S_WAITB = 3'd2,
    S_CSSET = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0]  c_cnv_last  = 4'(CNV_PULSE - 1);
  localparam logic [3:0]  c_div_last  = 4'(SCLK_DIV - 1);
  localparam logic [15:0] c_wait_last = 16'(BUSY_TIMEOUT - 1);
  localparam logic [4:0]  c_bit_last  = 5'd17;

  state_t      r_state;
  logic        r_busy_m;
  logic        r_busy_s;
  logic        r_sdo;
  logic        r_seen;     // busy_s has been observed high in this WAITB
  logic [3:0]  r_cnt;      // CNV pulse width / SCLK half-period counter
  logic [15:0] r_wcnt;     // WAITB dwell counter
  logic [4:0]  r_bits;     // bits captured so far
  logic [16:0] r_shift;    // first 17 bits; the 18th comes straight from r_sdo
  logic [15:0] r_count;

  assign COUNT = r_count;

  // BUSY is asynchronous: two-flop synchronizer. SDOUT gets one register so
  // the capture point sees a clean, timing-closed bit.
  always_ff @(negedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_busy_m <= 1'b0;
      r_busy_s <= 1'b0;
      r_sdo    <= 1'b0;
    end else begin
      r_busy_m <= ADBUSY;
      r_busy_s <= r_busy_m;
      r_sdo    <= ADSDOUT;
    end
  end

  always_ff @(negedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      ADCNVST <= 1'b0;
      ADCS    <= 1'b1;
      ADSCLK  <= 1'b0;
      DATA    <= 18'd0;
      DVALID  <= 1'b0;
      READY   <= 1'b1;
      ERR     <= 1'b0;
      r_count <= 16'd0;
      r_seen  <= 1'b0;
      r_cnt   <= 4'd0;
      r_wcnt  <= 16'd0;
      r_bits  <= 5'd0;
      r_shift <= 17'd0;
    end else begin
      DVALID <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state <= S_CNV;
            ADCNVST <= 1'b1;
            READY   <= 1'b0;
            ERR     <= 1'b0;
            r_cnt   <= 4'd0;
          end
        end

        S_CNV: begin
          if (r_cnt == c_cnv_last) begin
            ADCNVST <= 1'b0;
            r_state <= S_WAITB;
            r_cnt   <= 4'd0;
            r_wcnt  <= 16'd0;
            r_seen  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_WAITB: begin
          // A falling edge of busy_s wins over a simultaneous timeout.
          if (r_seen && !r_busy_s) begin
            r_state <= S_CSSET;
            ADCS    <= 1'b0;
          end else if (r_wcnt == c_wait_last) begin
            ERR     <= 1'b1;
            READY   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + 16'd1;
            if (r_busy_s) begin
              r_seen <= 1'b1;
            end
          end
        end

        S_CSSET: begin
          r_state <= S_SHIFT;
          r_cnt   <= 4'd0;
          r_bits  <= 5'd0;
        end

        S_SHIFT: begin
          if (r_cnt == c_div_last) begin
            r_cnt <= 4'd0;
            if (ADSCLK) begin
              // High->low: capture one bit; the last one ends the frame with
              // the clock parked low, so no 19th rising edge is produced.
              ADSCLK  <= 1'b0;
              r_shift <= {r_shift[15:0], r_sdo};
              if (r_bits == c_bit_last) begin
                r_state <= S_DONE;
                ADCS    <= 1'b1;
                DVALID  <= 1'b1;
                DATA    <= {r_shift, r_sdo};
                r_count <= r_count + 16'd1;
              end else begin
                r_bits <= r_bits + 5'd1;
              end
            end else begin
              ADSCLK <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_DONE: begin
          if (CONT) begin
            r_state <= S_CNV;
            ADCNVST <= 1'b1;
            r_cnt   <= 4'd0;
          end else begin
            r_state <= S_IDLE;
            READY   <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          ADCNVST <= 1'b0;
          ADCS    <= 1'b1;
          ADSCLK  <= 1'b0;
          READY   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad7643_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ad7643_reader                                           |
// | Description : Directed self-checking bench for ad7643_reader with a      |
// |               behavioural ADC (BUSY pulse + MSB-first serial word).      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ad7643_reader;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        START = 1'b0;
  logic        CONT = 1'b0;
  logic        ADCNVST;
  logic        ADCS;
  logic        ADSCLK;
  logic        ADSDOUT;
  logic        ADBUSY = 1'b0;
  logic [17:0] DATA;
  logic        DVALID;
  logic        READY;
  logic        ERR;
  logic [15:0] COUNT;

  int vectors = 0;
  int miscompares = 0;

  ad7643_reader dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .CONT(CONT),
    .ADCNVST(ADCNVST), .ADCS(ADCS), .ADSCLK(ADSCLK),
    .ADSDOUT(ADSDOUT), .ADBUSY(ADBUSY),
    .DATA(DATA), .DVALID(DVALID), .READY(READY), .ERR(ERR), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  // ---------------- ADC model ----------------
  logic [17:0] words [0:63];
  logic [5:0]  conv_idx = 6'd0;
  logic [17:0] cur_word = 18'd0;
  bit          busy_en = 1'b1;
  int          sclk_rises = 0;
  int          sclk_falls = 0;
  int          falls_at_cs = 0;
  int          dv_count = 0;
  int          k;

  always @(posedge ADCNVST) begin
    cur_word = words[conv_idx];
    conv_idx = conv_idx + 6'd1;
    if (busy_en) begin
      ADBUSY = 1'b1;
      repeat (160) @(posedge CLK);
      ADBUSY = 1'b0;
    end
  end

  always @(posedge ADSCLK) sclk_rises++;
  always @(negedge ADSCLK) sclk_falls++;
  always @(negedge ADCS) falls_at_cs = sclk_falls;
  always @(posedge CLK) if (DVALID === 1'b1) dv_count++;

  // MSB presented when CS falls; next bit after every ADSCLK falling edge.
  always_comb begin
    k = 17 - (sclk_falls - falls_at_cs);
    ADSDOUT = (k >= 0 && k <= 17) ? cur_word[k[4:0]] : 1'b0;
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic apply_reset();
    @(posedge CLK);
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    RSTN = 1'b1;
    repeat (2) @(posedge CLK);
  endtask

  task automatic pulse_start();
    @(posedge CLK);
    START = 1'b1;
    @(posedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_dvalid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (DVALID === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge CLK);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 RSTN = 1'b0;
    #1;
    vectors++; if (ADCNVST !== 1'b0) begin miscompares++; $display("FAIL reset_adcnvst got=%b exp=0", ADCNVST); end
    vectors++; if (ADCS !== 1'b1) begin miscompares++; $display("FAIL reset_adcs got=%b exp=1", ADCS); end
    vectors++; if (ADSCLK !== 1'b0) begin miscompares++; $display("FAIL reset_adsclk got=%b exp=0", ADSCLK); end
    vectors++; if (DATA !== 18'h0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", DATA); end
    vectors++; if (DVALID !== 1'b0) begin miscompares++; $display("FAIL reset_dvalid got=%b exp=0", DVALID); end
    vectors++; if (READY !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", READY); end
    vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", ERR); end
    vectors++; if (COUNT !== 16'h0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
    repeat (3) @(posedge CLK);
    RSTN = 1'b1;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_single_shot();
    int r0, d0;
    bit got;
    r0 = sclk_rises; d0 = dv_count;
    words[conv_idx] = 18'h2AAAA;
    pulse_start();
    for (int i = 1; i <= 4; i++) begin
      vectors++; if (ADCNVST !== 1'b1) begin miscompares++; $display("FAIL single_cnv_high cycle=%0d got=%b exp=1", i, ADCNVST); end
      if (i == 2) begin
        vectors++; if (ADCS !== 1'b1 || ADSCLK !== 1'b0) begin miscompares++; $display("FAIL single_cnv_bus cs=%b sclk=%b exp cs=1 sclk=0", ADCS, ADSCLK); end
      end
      @(posedge CLK);
    end
    vectors++; if (ADCNVST !== 1'b0) begin miscompares++; $display("FAIL single_cnv_end got=%b exp=0", ADCNVST); end
    wait_dvalid(got);
    vectors++; if (!got) begin miscompares++; $display("FAIL single_dvalid_timeout got=none exp=strobe"); end
    vectors++; if (DATA !== 18'h2AAAA) begin miscompares++; $display("FAIL single_data got=%h exp=2aaaa", DATA); end
    repeat (3) @(posedge CLK);
    vectors++; if (sclk_rises - r0 !== 18) begin miscompares++; $display("FAIL single_sclk_periods got=%0d exp=18", sclk_rises - r0); end
    vectors++; if (dv_count - d0 !== 1) begin miscompares++; $display("FAIL single_dvalid_count got=%0d exp=1", dv_count - d0); end
    vectors++; if (COUNT !== 16'd1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", COUNT); end
    vectors++; if (READY !== 1'b1) begin miscompares++; $display("FAIL single_ready got=%b exp=1", READY); end
    vectors++; if (DATA !== 18'h2AAAA) begin miscompares++; $display("FAIL single_data_hold got=%h exp=2aaaa", DATA); end
  endtask

  task automatic test_msb_lsb();
    bit got;
    words[conv_idx] = 18'h20000;
    pulse_start();
    wait_dvalid(got);
    vectors++; if (!got || DATA !== 18'h20000) begin miscompares++; $display("FAIL msb_data got=%h exp=20000", DATA); end
    repeat (2) @(posedge CLK);
    words[conv_idx] = 18'h00001;
    pulse_start();
    wait_dvalid(got);
    vectors++; if (!got || DATA !== 18'h00001) begin miscompares++; $display("FAIL lsb_data got=%h exp=00001", DATA); end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_continuous();
    int d0;
    bit got;
    apply_reset();
    for (int i = 0; i < 5; i++) words[conv_idx + 6'(i)] = 18'(i);
    d0 = dv_count;
    CONT = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      wait_dvalid(got);
      vectors++; if (!got || DATA !== 18'(i)) begin miscompares++; $display("FAIL cont_data idx=%0d got=%h exp=%h", i, DATA, 18'(i)); end
      if (i == 4) CONT = 1'b0;
      @(posedge CLK);
      if (i < 4) begin
        vectors++; if (ADCNVST !== 1'b1) begin miscompares++; $display("FAIL cont_restart idx=%0d got=%b exp=1", i, ADCNVST); end
      end else begin
        vectors++; if (READY !== 1'b1) begin miscompares++; $display("FAIL cont_ready got=%b exp=1", READY); end
      end
    end
    repeat (400) @(posedge CLK);
    vectors++; if (dv_count - d0 !== 5) begin miscompares++; $display("FAIL cont_dvalid_count got=%0d exp=5", dv_count - d0); end
    vectors++; if (COUNT !== 16'd5) begin miscompares++; $display("FAIL cont_count got=%0d exp=5", COUNT); end
  endtask

  task automatic test_cont_stop();
    int d0;
    bit got;
    for (int i = 0; i < 5; i++) words[conv_idx + 6'(i)] = 18'h10 + 18'(i);
    d0 = dv_count;
    CONT = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_dvalid(got);
      vectors++; if (!got || DATA !== 18'h10 + 18'(i)) begin miscompares++; $display("FAIL stop_data idx=%0d got=%h exp=%h", i, DATA, 18'h10 + 18'(i)); end
      if (i == 2) CONT = 1'b0;
      @(posedge CLK);
    end
    repeat (400) @(posedge CLK);
    vectors++; if (dv_count - d0 !== 3) begin miscompares++; $display("FAIL stop_dvalid_count got=%0d exp=3", dv_count - d0); end
    vectors++; if (READY !== 1'b1) begin miscompares++; $display("FAIL stop_ready got=%b exp=1", READY); end
    vectors++; if (COUNT !== 16'd8) begin miscompares++; $display("FAIL stop_count got=%0d exp=8", COUNT); end
  endtask

  task automatic test_timeout();
    int d0, n;
    bit got;
    d0 = dv_count;
    busy_en = 1'b0;
    pulse_start();
    n = 1;
    while (ERR !== 1'b1 && n < 400) begin
      @(posedge CLK);
      n++;
    end
    vectors++; if (n !== 260) begin miscompares++; $display("FAIL timeout_latency got=%0d exp=260", n); end
    vectors++; if (READY !== 1'b1) begin miscompares++; $display("FAIL timeout_ready got=%b exp=1", READY); end
    vectors++; if (dv_count - d0 !== 0) begin miscompares++; $display("FAIL timeout_dvalid got=%0d exp=0", dv_count - d0); end
    vectors++; if (COUNT !== 16'd8) begin miscompares++; $display("FAIL timeout_count got=%0d exp=8", COUNT); end
    repeat (5) @(posedge CLK);
    vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky got=%b exp=1", ERR); end
    busy_en = 1'b1;
    words[conv_idx] = 18'h3FFFF;
    pulse_start();
    vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL timeout_err_clear got=%b exp=0", ERR); end
    wait_dvalid(got);
    vectors++; if (!got || DATA !== 18'h3FFFF) begin miscompares++; $display("FAIL timeout_next_data got=%h exp=3ffff", DATA); end
    repeat (2) @(posedge CLK);
    vectors++; if (COUNT !== 16'd9) begin miscompares++; $display("FAIL timeout_next_count got=%0d exp=9", COUNT); end
  endtask

  task automatic test_reset_mid_shift();
    int d0, f0, n;
    bit got;
    words[conv_idx] = 18'h15555;
    d0 = dv_count; f0 = sclk_falls;
    pulse_start();
    n = 0;
    while (sclk_falls - f0 < 9 && n < 2000) begin
      @(posedge CLK);
      n++;
    end
    vectors++; if (n >= 2000) begin miscompares++; $display("FAIL midshift_reach got=%0d falls exp=9", sclk_falls - f0); end
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b0;
    #1;
    vectors++; if (ADCS !== 1'b1) begin miscompares++; $display("FAIL midshift_adcs got=%b exp=1", ADCS); end
    vectors++; if (ADSCLK !== 1'b0) begin miscompares++; $display("FAIL midshift_adsclk got=%b exp=0", ADSCLK); end
    vectors++; if (COUNT !== 16'd0) begin miscompares++; $display("FAIL midshift_count got=%0d exp=0", COUNT); end
    repeat (3) @(posedge CLK);
    RSTN = 1'b1;
    repeat (300) @(posedge CLK);
    vectors++; if (dv_count - d0 !== 0) begin miscompares++; $display("FAIL midshift_dvalid got=%0d exp=0", dv_count - d0); end
    words[conv_idx] = 18'h0C3A5;
    pulse_start();
    vectors++; if (ADCNVST !== 1'b1) begin miscompares++; $display("FAIL midshift_fresh_cnv got=%b exp=1", ADCNVST); end
    wait_dvalid(got);
    vectors++; if (!got || DATA !== 18'h0C3A5) begin miscompares++; $display("FAIL midshift_fresh_data got=%h exp=0c3a5", DATA); end
    repeat (2) @(posedge CLK);
    vectors++; if (COUNT !== 16'd1) begin miscompares++; $display("FAIL midshift_fresh_count got=%0d exp=1", COUNT); end
  endtask

  task automatic test_count_wrap();
    bit got;
    @(posedge CLK);
    force dut.r_count = 16'hFFFF;
    @(posedge CLK);
    release dut.r_count;
    words[conv_idx] = 18'h12345;
    pulse_start();
    wait_dvalid(got);
    vectors++; if (!got || DATA !== 18'h12345) begin miscompares++; $display("FAIL wrap_data got=%h exp=12345", DATA); end
    repeat (2) @(posedge CLK);
    vectors++; if (COUNT !== 16'd0) begin miscompares++; $display("FAIL wrap_count got=%0d exp=0", COUNT); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) words[i] = 18'h0;
    test_reset();
    test_single_shot();
    test_msb_lsb();
    test_continuous();
    test_cont_stop();
    test_timeout();
    test_reset_mid_shift();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
